sqrt_job_sequencer: RTL and testbench

Upstream issue stage for the square-root unit. Accepts operand pairs (A, B) over a valid/ready handshake into a small FIFO and launches one job at a time. For each job it holds the operands stable, pulses Start for one cycle, waits a fixed LATENCY, and captures O into a result register. The result is presented downstream with valid/ready, so the engine, which has no done or ready signal, can sit in a streaming pipeline.

---
 rtl/sqrt_job_sequencer.sv | 138 +++++++++++++
 tb/tb_sqrt_job_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_job_sequencer.sv
// Issue stage for the square-root engine: buffers operand pairs in a small
// FIFO, launches one job at a time with a one-cycle Start pulse, waits a fixed
// latency, captures the engine result and offers it downstream with
// valid/ready.
module sqrt_job_sequencer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LATENCY = 20,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [WIDTH-1:0]         sq_a,
  output logic [WIDTH-1:0]         sq_b,
  output logic                     sq_start,
  input  logic [WIDTH-1:0]         sq_o,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_o,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]       state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] sq_a_d, sq_b_d, out_o_d;
  logic             start_d, out_valid_d;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level_d;
  logic             push_c, pop_c;

  // FIFO handshake derived from the registered occupancy only
  assign in_ready = (level < LW'(DEPTH));
  assign push_c   = in_valid & in_ready;
  assign busy     = (state != S_IDLE) || (level != '0);
  assign level_d  = level + LW'(push_c) - LW'(pop_c);

  // Operand storage; entries are discarded on reset by clearing the pointers
  always_ff @(posedge Clk) begin
    if (push_c) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // Job sequencing: next state and next values of every registered output
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    sq_a_d      = sq_a;
    sq_b_d      = sq_b;
    start_d     = 1'b0;
    out_valid_d = out_valid;
    out_o_d     = out_o;
    pop_c       = 1'b0;
    case (state)
      S_IDLE: begin
        if (level != '0) begin
          state_d = S_LAUNCH;
          sq_a_d  = mem_a[rd_ptr];
          sq_b_d  = mem_b[rd_ptr];
          start_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        cnt_d   = CW'(LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == '0) begin
          out_o_d     = sq_o;
          out_valid_d = 1'b1;
          pop_c       = 1'b1;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (level != '0) begin
            state_d = S_LAUNCH;
            sq_a_d  = mem_a[rd_ptr];
            sq_b_d  = mem_b[rd_ptr];
            start_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, outputs and FIFO bookkeeping registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sq_a      <= '0;
      sq_b      <= '0;
      sq_start  <= 1'b0;
      out_valid <= 1'b0;
      out_o     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      sq_a      <= sq_a_d;
      sq_b      <= sq_b_d;
      sq_start  <= start_d;
      out_valid <= out_valid_d;
      out_o     <= out_o_d;
      level     <= level_d;
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

endmodule

// File: tb/tb_sqrt_job_sequencer.sv
// Bench for sqrt_job_sequencer: engine stub plus a transaction-level model of
// the FIFO, job launch timing and result handshake.
module tb_sqrt_job_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 4;

  logic              Clk, Reset;
  logic              in_valid, in_ready, sq_start, out_valid, out_ready, busy;
  logic [WIDTH-1:0]  in_a, in_b, sq_a, sq_b, sq_o, out_o;
  logic [2:0]        level;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [15:0] mq_a[$], mq_b[$], snd_a[$], snd_b[$], got[$], exp_res[$];
  int          starts[$];
  bit          m_job, m_ov, rnd_ready;
  int          m_t, cyc, ov_rise;
  logic [15:0] m_out, m_sqa, m_sqb;
  logic        prev_ov;

  // Engine stub state
  int          eng_age;
  logic [15:0] eng_res;

  sqrt_job_sequencer #(.WIDTH(WIDTH), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .sq_a(sq_a), .sq_b(sq_b), .sq_start(sq_start), .sq_o(sq_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_o(out_o),
    .busy(busy), .level(level)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int isqrt(input int n);
    int r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  // Engine: O is meaningful only in the cycle LAT cycles after Start
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      eng_age <= 0;
      eng_res <= '0;
    end else if (sq_start) begin
      eng_age <= 1;
      eng_res <= 16'(isqrt(int'(sq_a) * int'(sq_a) + int'(sq_b) * int'(sq_b)));
    end else if (eng_age != 0 && eng_age < 1000) begin
      eng_age <= eng_age + 1;
    end
  end
  assign sq_o = (eng_age == LAT) ? eng_res : 16'hFFFF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    snd_a.push_back(a);
    snd_b.push_back(b);
    exp_res.push_back(16'(isqrt(int'(a) * int'(a) + int'(b) * int'(b))));
  endtask

  task automatic reset_model();
    mq_a.delete(); mq_b.delete(); snd_a.delete(); snd_b.delete();
    got.delete(); exp_res.delete(); starts.delete();
    m_job = 0; m_ov = 0; m_t = 0; m_out = '0; m_sqa = '0; m_sqb = '0;
    prev_ov = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_sq_a", sq_a, 0);
    chk("rst_sq_b", sq_b, 0);
    chk("rst_sq_start", sq_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_o", out_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  // One clock: drive at negedge, advance model across posedge, check at negedge
  task automatic tick();
    bit push, cap, acc, launch;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    if (snd_a.size() > 0) begin
      in_valid = 1'b1; in_a = snd_a[0]; in_b = snd_b[0];
    end else begin
      in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom);
    end
    push   = in_valid && (mq_a.size() < DEPTH);
    acc    = m_ov && out_ready;
    cap    = m_job && (m_t == LAT);
    launch = !m_job && (!m_ov || acc) && (mq_a.size() > 0);
    if (acc) got.push_back(out_o);
    @(posedge Clk);
    cyc++;
    if (m_job) m_t++;
    if (acc) m_ov = 0;
    if (cap) begin
      m_out = 16'(isqrt(int'(mq_a[0]) * int'(mq_a[0]) + int'(mq_b[0]) * int'(mq_b[0])));
      void'(mq_a.pop_front());
      void'(mq_b.pop_front());
      m_ov  = 1;
      m_job = 0;
    end
    if (launch) begin
      m_job = 1; m_t = 0; m_sqa = mq_a[0]; m_sqb = mq_b[0];
    end
    if (push) begin
      mq_a.push_back(in_a);
      mq_b.push_back(in_b);
      void'(snd_a.pop_front());
      void'(snd_b.pop_front());
    end
    @(negedge Clk);
    chk("sq_start", sq_start, 32'(m_job && m_t == 0));
    chk("sq_a", sq_a, m_sqa);
    chk("sq_b", sq_b, m_sqb);
    chk("out_valid", out_valid, 32'(m_ov));
    chk("out_o", out_o, m_out);
    chk("level", level, mq_a.size());
    chk("in_ready", in_ready, 32'(mq_a.size() < DEPTH));
    chk("busy", busy, 32'(m_job || m_ov || mq_a.size() > 0));
    if (sq_start) starts.push_back(cyc);
    if (out_valid && !prev_ov) ov_rise = cyc;
    prev_ov = out_valid;
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    if (!rnd_ready) out_ready = 1'b1;
    while ((snd_a.size() > 0 || m_job || m_ov || mq_a.size() > 0) && k < maxc) begin
      tick();
      k++;
    end
    chk("drain_timeout", 32'(k < maxc), 1);
  endtask

  task automatic check_results();
    chk("n_results", got.size(), exp_res.size());
    for (int i = 0; i < got.size() && i < exp_res.size(); i++) chk("result", got[i], exp_res[i]);
    got.delete();
    exp_res.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, k;
    int k4[4];
    k4 = '{5, 13, 17, 0};
    Reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    rnd_ready = 0; cyc = 0; ov_rise = -1;
    reset_model();
    #12;
    check_reset_outputs();
    @(negedge Clk); Reset = 1'b1;
    repeat (3) tick();

    // Single job (3,4) with backpressure, then fill the FIFO behind it
    out_ready = 1'b0;
    send(16'd3, 16'd4);
    tick();
    c0 = cyc;
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    chk("t1_wait", 32'(k < 20), 1);
    chk("t1_start_cyc", (starts.size() > 0) ? starts[0] : -1, c0 + 1);
    chk("t1_ov_latency", (starts.size() > 0) ? ov_rise - starts[0] : -1, LAT + 1);
    chk("t1_out", out_o, 5);
    for (int i = 0; i < 5; i++) send(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
    repeat (10) tick();
    chk("bp_out_held", out_o, 5);
    chk("bp_valid_held", out_valid, 1);
    chk("bp_one_start", starts.size(), 1);
    chk("bp_level_full", level, DEPTH);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_fifth_waiting", snd_a.size(), 1);
    drain(300);
    check_results();

    // Four back-to-back jobs with out_ready held high
    starts.delete();
    send(16'd3, 16'd4); send(16'd5, 16'd12); send(16'd8, 16'd15); send(16'd0, 16'd0);
    drain(200);
    for (int i = 0; i < 4; i++) chk("b2b_value", (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, k4[i]);
    chk("b2b_starts", starts.size(), 4);
    for (int i = 1; i < starts.size(); i++) chk("b2b_spacing", starts[i] - starts[i-1], LAT + 2);
    chk("b2b_level", level, 0);
    chk("b2b_busy", busy, 0);
    check_results();

    // Ten random jobs with random downstream backpressure (pointer wrap)
    rnd_ready = 1;
    for (int i = 0; i < 10; i++) send(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
    drain(800);
    rnd_ready = 0;
    check_results();

    // Push and pop on the same edge at level 2
    out_ready = 1'b1;
    send(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
    send(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
    k = 0;
    while (!(m_job && m_t == LAT && snd_a.size() == 0) && k < 50) begin tick(); k++; end
    chk("pp_wait", 32'(k < 50), 1);
    chk("pp_level_before", level, 2);
    send(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
    tick();
    chk("pp_level_after", level, 2);
    chk("pp_in_ready", in_ready, 1);
    drain(200);
    check_results();

    // Reset while a job is waiting with further entries queued
    send(16'd9, 16'd12); send(16'd1, 16'd1); send(16'd2, 16'd2);
    k = 0;
    while (!(m_job && m_t >= 2 && mq_a.size() >= 2) && k < 30) begin tick(); k++; end
    chk("rst_wait", 32'(k < 30), 1);
    Reset = 1'b0; in_valid = 1'b0;
    #1;
    check_reset_outputs();
    reset_model();
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (10) tick();
    chk("rst_no_start", starts.size(), 0);
    send(16'd6, 16'd8);
    drain(100);
    chk("rst_next_n", got.size(), 1);
    chk("rst_next_val", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF_FFFF, 10);
    check_results();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
